// File: rtl/arbitro_bus_3.sv
// arbitro_bus_3: round-robin arbiter and sequencer for the shared 3-input,
// 16-bit datapath source mux. It issues one-hot grants in the order
// A -> B -> C -> A, limits each grant window to MAX_CICLOS cycles, and
// drives a registered mux select that never takes the illegal code 2'd3.
module arbitro_bus_3 #(
  parameter int MAX_CICLOS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] Req,
  output logic [2:0] Grant,
  output logic [1:0] Sel,
  output logic       Ocupado,
  output logic       Rotacion
);

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } estadoT;

  localparam logic [7:0] maxBeats = 8'(MAX_CICLOS);

  // Requester indices use the Sel encoding: A=2, B=1, C=0.
  localparam logic [1:0] idxA = 2'd2;
  localparam logic [1:0] idxB = 2'd1;
  localparam logic [1:0] idxC = 2'd0;

  estadoT     estado;
  estadoT     estadoNext;
  logic [1:0] ultimo;
  logic [1:0] ultimoNext;
  logic [7:0] beats;
  logic [7:0] beatsNext;
  logic [2:0] grantNext;
  logic [1:0] selNext;
  logic       ocupadoNext;
  logic       rotacionNext;

  logic       holderReq;
  logic       liberar;
  logic       nuevaConcesion;
  logic [1:0] base;
  logic [1:0] cand1;
  logic [1:0] cand2;
  logic       hayGanador;
  logic [1:0] ganador;

  // Successor in round-robin order: C(0) -> A(2) -> B(1) -> C(0).
  function automatic logic [1:0] siguiente(input logic [1:0] idx);
    logic [1:0] res;
    case (idx)
      idxC:    res = idxA;
      idxA:    res = idxB;
      default: res = idxC;
    endcase
    return res;
  endfunction

  // Request line belonging to a requester index.
  function automatic logic reqDe(input logic [2:0] r, input logic [1:0] idx);
    logic res;
    case (idx)
      idxA:    res = r[2];
      idxB:    res = r[1];
      idxC:    res = r[0];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // One-hot grant pattern for a requester index.
  function automatic logic [2:0] unoCaliente(input logic [1:0] idx);
    logic [2:0] res;
    case (idx)
      idxA:    res = 3'b100;
      idxB:    res = 3'b010;
      idxC:    res = 3'b001;
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  // Release detection and round-robin winner search; while granted the
  // holder is the current Sel value, and on release it becomes the base.
  always_comb begin
    holderReq  = reqDe(Req, Sel);
    liberar    = (estado == GRANTED) && (!holderReq || (beats == maxBeats));
    base       = liberar ? Sel : ultimo;
    cand1      = siguiente(base);
    cand2      = siguiente(cand1);
    hayGanador = 1'b1;
    ganador    = base;
    if (reqDe(Req, cand1)) begin
      ganador = cand1;
    end else if (reqDe(Req, cand2)) begin
      ganador = cand2;
    end else if (reqDe(Req, base)) begin
      ganador = base;
    end else begin
      hayGanador = 1'b0;
    end
    nuevaConcesion = hayGanador && ((estado == IDLE) || liberar);
  end

  // State register plus all registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= IDLE;
      ultimo   <= idxC;
      beats    <= 8'd0;
      Grant    <= 3'b000;
      Sel      <= 2'd0;
      Ocupado  <= 1'b0;
      Rotacion <= 1'b0;
    end else begin
      estado   <= estadoNext;
      ultimo   <= ultimoNext;
      beats    <= beatsNext;
      Grant    <= grantNext;
      Sel      <= selNext;
      Ocupado  <= ocupadoNext;
      Rotacion <= rotacionNext;
    end
  end

  // Next FSM state: enter or stay GRANTED while someone is being served.
  always_comb begin
    estadoNext = estado;
    case (estado)
      IDLE: begin
        if (hayGanador) begin
          estadoNext = GRANTED;
        end
      end
      GRANTED: begin
        if (liberar && !hayGanador) begin
          estadoNext = IDLE;
        end
      end
      default: estadoNext = IDLE;
    endcase
  end

  // Next values of the window counter, last holder and registered outputs.
  always_comb begin
    grantNext    = Grant;
    selNext      = Sel;
    beatsNext    = beats;
    ultimoNext   = ultimo;
    rotacionNext = 1'b0;
    if (liberar) begin
      ultimoNext = Sel;
    end
    if (nuevaConcesion) begin
      grantNext    = unoCaliente(ganador);
      selNext      = ganador;
      beatsNext    = 8'd1;
      rotacionNext = 1'b1;
    end else if (liberar) begin
      grantNext = 3'b000;
      beatsNext = 8'd0;
    end else if (estado == GRANTED) begin
      beatsNext = beats + 8'd1;
    end
    ocupadoNext = (grantNext != 3'b000);
  end

endmodule

// File: tb/tb_arbitro_bus_3.sv
// tb_arbitro_bus_3: self-checking bench for arbitro_bus_3 with directed
// scenarios and random traffic compared against a behavioural model.
module tb_arbitro_bus_3;

  localparam int MAXC = 4;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic [2:0] grant;
  logic [1:0] sel;
  logic       ocupado;
  logic       rotacion;

  int assertCount = 0;
  int failCount   = 0;

  // Model state. Requesters are ordinals in rotation order: A=0, B=1, C=2.
  bit         mBusy;
  int         mHolder;
  int         mLast;
  int         mBeats;
  bit         mRot;
  logic [1:0] mSel;

  arbitro_bus_3 #(.MAX_CICLOS(MAXC)) dut (
    .clk     (clk),
    .reset   (reset),
    .Req     (req),
    .Grant   (grant),
    .Sel     (sel),
    .Ocupado (ocupado),
    .Rotacion(rotacion)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit wants(input logic [2:0] r, input int ord);
    return r[2 - ord];
  endfunction

  // Advance the behavioural model by one clock edge.
  task automatic stepModel(input logic [2:0] r, input logic rst);
    bit doArb;
    bit found;
    if (rst) begin
      mBusy  = 0;
      mLast  = 2;
      mBeats = 0;
      mRot   = 0;
      mSel   = 2'd0;
      return;
    end
    mRot  = 0;
    doArb = 0;
    if (!mBusy) begin
      doArb = (r != 3'b000);
    end else if (!wants(r, mHolder) || mBeats == MAXC) begin
      mLast = mHolder;
      doArb = 1;
    end else begin
      mBeats++;
    end
    if (doArb) begin
      found = 0;
      for (int k = 1; k <= 3; k++) begin
        if (!found && wants(r, (mLast + k) % 3)) begin
          found   = 1;
          mHolder = (mLast + k) % 3;
        end
      end
      if (found) begin
        mBusy  = 1;
        mBeats = 1;
        mRot   = 1;
        mSel   = 2'(2 - mHolder);
      end else begin
        mBusy  = 0;
        mBeats = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare DUT with the model.
  task automatic applyStimulus(input logic [2:0] r, input logic rst);
    logic [2:0] expGrant;
    reset = rst;
    req   = r;
    @(posedge clk);
    stepModel(r, rst);
    #1;
    expGrant = mBusy ? (3'b100 >> mHolder) : 3'b000;
    checkOutput("grant",    {5'd0, grant},    {5'd0, expGrant});
    checkOutput("sel",      {6'd0, sel},      {6'd0, mSel});
    checkOutput("ocupado",  {7'd0, ocupado},  {7'd0, (expGrant != 3'b000)});
    checkOutput("rotacion", {7'd0, rotacion}, {7'd0, mRot});
  endtask

  initial begin
    reset = 1'b1;
    req   = 3'b000;
    @(negedge clk);

    // Reset held two cycles with random requests.
    applyStimulus(3'($urandom), 1'b1);
    applyStimulus(3'($urandom), 1'b1);
    checkOutput("resetGrant", {5'd0, grant}, 8'h00);
    checkOutput("resetSel",   {6'd0, sel},   8'h00);

    // Full contention from reset: A, B, C, A windows of four cycles.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(3'b111, 1'b0);
      if (i == 0)  checkOutput("firstGrantA", {5'd0, grant}, 8'h04);
      if (i == 4)  checkOutput("contentionB", {5'd0, grant}, 8'h02);
      if (i == 8)  checkOutput("contentionC", {6'd0, sel},   8'h00);
      if (i == 12) checkOutput("contentionA", {6'd0, sel},   8'h02);
    end

    // Sole requester B re-granted back-to-back after each timeout.
    applyStimulus(3'b000, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(3'b010, 1'b0);
      checkOutput("soloGrantB", {5'd0, grant}, 8'h02);
      if (i == 5) checkOutput("soloRotacion5", {7'd0, rotacion}, 8'h01);
    end

    // Early drop by A after two cycles; Sel holds 2 while idle.
    applyStimulus(3'b000, 1'b1);
    applyStimulus(3'b100, 1'b0);
    applyStimulus(3'b100, 1'b0);
    applyStimulus(3'b000, 1'b0);
    applyStimulus(3'b000, 1'b0);
    checkOutput("dropGrant", {5'd0, grant}, 8'h00);
    checkOutput("dropSel",   {6'd0, sel},   8'h02);

    // C holds while A and B request, then C drops: A comes next.
    applyStimulus(3'b000, 1'b1);
    applyStimulus(3'b001, 1'b0);
    applyStimulus(3'b111, 1'b0);
    applyStimulus(3'b110, 1'b0);
    checkOutput("handoffGrant",    {5'd0, grant},    8'h04);
    checkOutput("handoffRotacion", {7'd0, rotacion}, 8'h01);

    // Reset in the second cycle of a B window, then Req=011 goes to B.
    applyStimulus(3'b000, 1'b1);
    applyStimulus(3'b010, 1'b0);
    applyStimulus(3'b010, 1'b0);
    applyStimulus(3'b010, 1'b1);
    checkOutput("midResetGrant", {5'd0, grant}, 8'h00);
    checkOutput("midResetSel",   {6'd0, sel},   8'h00);
    applyStimulus(3'b011, 1'b0);
    checkOutput("afterResetB", {5'd0, grant}, 8'h02);

    // Random traffic with occasional resets; requests tend to persist.
    for (int i = 0; i < 400; i++) begin
      logic [2:0] r;
      r = ($urandom_range(0, 3) == 0) ? 3'($urandom) : req;
      applyStimulus(r, ($urandom_range(0, 59) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
